// File: rtl/key_event.sv
// key_event: converts debounced key levels into one-cycle press/release/
// long/repeat pulses plus held/long_held status levels, one lane per key.

// One key channel: edge detector, IDLE/PRESSED/LONG FSM and a saturating counter.
module key_event_lane #(
    parameter int hold_cycles   = 25_000_000,
    parameter int repeat_cycles = 5_000_000,
    parameter int cw            = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_in,
    output logic press,
    output logic release_pulse,
    output logic long,
    output logic repeat_pulse,
    output logic held,
    output logic long_held
);
    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

    // Counter values at which the next in-progress cycle completes the period.
    localparam logic [cw-1:0] hold_last = cw'(hold_cycles - 1);
    localparam logic [cw-1:0] rpt_last  = cw'((repeat_cycles == 0) ? 0 : repeat_cycles - 1);
    localparam logic [cw-1:0] one       = cw'(1);

    state_t        state, state_nx;
    logic [cw-1:0] cnt, cnt_nx;
    logic          sw_q;
    logic          press_nx, rel_nx, long_nx, rpt_nx;

    // State, counter and every output are registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            sw_q          <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long          <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            long_held     <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            sw_q          <= sw_in;
            press         <= press_nx;
            release_pulse <= rel_nx;
            long          <= long_nx;
            repeat_pulse  <= rpt_nx;
            held          <= (state_nx != IDLE);
            long_held     <= (state_nx == LONG);
        end
    end

    // Next state and pulses; release is tested first so it wins over long/repeat.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        press_nx = 1'b0;
        rel_nx   = 1'b0;
        long_nx  = 1'b0;
        rpt_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (sw_in && !sw_q) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                    press_nx = 1'b1;
                end
            end
            PRESSED: begin
                if (!sw_in) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    rel_nx   = 1'b1;
                end else if (cnt == hold_last) begin
                    state_nx = LONG;
                    cnt_nx   = '0;
                    long_nx  = 1'b1;
                end else if (cnt != '1) begin
                    cnt_nx = cnt + one;
                end
            end
            LONG: begin
                if (!sw_in) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    rel_nx   = 1'b1;
                end else if (repeat_cycles != 0) begin
                    if (cnt == rpt_last) begin
                        cnt_nx = '0;
                        rpt_nx = 1'b1;
                    end else if (cnt != '1) begin
                        cnt_nx = cnt + one;
                    end
                end else begin
                    cnt_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end
endmodule

module key_event #(
    parameter int w             = 1,
    parameter int hold_cycles   = 25_000_000,
    parameter int repeat_cycles = 5_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [w-1:0] sw_in,
    output logic [w-1:0] press,
    output logic [w-1:0] release_pulse,
    output logic [w-1:0] long,
    output logic [w-1:0] repeat_pulse,
    output logic [w-1:0] held,
    output logic [w-1:0] long_held
);
    localparam int max_cycles = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
    localparam int cw         = $clog2(max_cycles + 1);

    // One independent lane per key channel.
    for (genvar i = 0; i < w; i++) begin : g_lane
        key_event_lane #(
            .hold_cycles  (hold_cycles),
            .repeat_cycles(repeat_cycles),
            .cw           (cw)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .sw_in        (sw_in[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .long         (long[i]),
            .repeat_pulse (repeat_pulse[i]),
            .held         (held[i]),
            .long_held    (long_held[i])
        );
    end
endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: a repeat-enabled and a repeat-disabled instance share
// the same stimulus and are compared against an age-based reference model.
module tb_key_event;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sw_in;
    logic [1:0] o_press [2];
    logic [1:0] o_rel   [2];
    logic [1:0] o_long  [2];
    logic [1:0] o_rpt   [2];
    logic [1:0] o_held  [2];
    logic [1:0] o_lheld [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_event #(.w(2), .hold_cycles(HOLD), .repeat_cycles(4)) dut (
        .clk(clk), .reset(reset), .sw_in(sw_in),
        .press(o_press[0]), .release_pulse(o_rel[0]), .long(o_long[0]),
        .repeat_pulse(o_rpt[0]), .held(o_held[0]), .long_held(o_lheld[0])
    );

    key_event #(.w(2), .hold_cycles(HOLD), .repeat_cycles(0)) dut_nr (
        .clk(clk), .reset(reset), .sw_in(sw_in),
        .press(o_press[1]), .release_pulse(o_rel[1]), .long(o_long[1]),
        .repeat_pulse(o_rpt[1]), .held(o_held[1]), .long_held(o_lheld[1])
    );

    // Reference model: a key is either idle or active with an age counted
    // from its press pulse; events follow from the age arithmetic.
    bit         m_act  [2][2];
    int         m_age  [2][2];
    bit         m_prev [2][2];
    logic [1:0] e_press[2], e_rel[2], e_long[2], e_rpt[2], e_held[2], e_lheld[2];

    function automatic int rc_of(int d);
        return (d == 0) ? 4 : 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                m_act[d][c] = 0; m_age[d][c] = 0; m_prev[d][c] = 0;
            end
            e_press[d] = '0; e_rel[d] = '0; e_long[d] = '0;
            e_rpt[d] = '0; e_held[d] = '0; e_lheld[d] = '0;
        end
    endtask

    task automatic model_edge(input logic [1:0] sw);
        for (int d = 0; d < 2; d++) begin
            e_press[d] = '0; e_rel[d] = '0; e_long[d] = '0; e_rpt[d] = '0;
            for (int c = 0; c < 2; c++) begin
                if (m_act[d][c]) begin
                    if (!sw[c]) begin
                        e_rel[d][c] = 1'b1;
                        m_act[d][c] = 0;
                    end else begin
                        m_age[d][c]++;
                        if (m_age[d][c] == HOLD) e_long[d][c] = 1'b1;
                        if (rc_of(d) != 0 && m_age[d][c] > HOLD &&
                            (m_age[d][c] - HOLD) % rc_of(d) == 0) e_rpt[d][c] = 1'b1;
                    end
                end else if (sw[c] && !m_prev[d][c]) begin
                    e_press[d][c] = 1'b1;
                    m_act[d][c] = 1;
                    m_age[d][c] = 0;
                end
                m_prev[d][c] = sw[c];
                e_held[d][c]  = m_act[d][c];
                e_lheld[d][c] = m_act[d][c] && m_age[d][c] >= HOLD;
            end
        end
    endtask

    function automatic logic [11:0] got_of(int d);
        return {o_press[d], o_rel[d], o_long[d], o_rpt[d], o_held[d], o_lheld[d]};
    endfunction

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (press,rel,long,rpt,held,lheld) t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b t=%0t", name, got, exp, $time);
        end
    endtask

    // Drive one sample, advance one edge, compare both instances to the model.
    task automatic step(input logic [1:0] sw);
        sw_in = sw;
        @(posedge clk);
        model_edge(sw);
        #1;
        chk("model_rpt4", got_of(0), {e_press[0], e_rel[0], e_long[0], e_rpt[0], e_held[0], e_lheld[0]});
        chk("model_rpt0", got_of(1), {e_press[1], e_rel[1], e_long[1], e_rpt[1], e_held[1], e_lheld[1]});
    endtask

    typedef struct packed {
        logic [1:0] sw;
        logic [1:0] press, rel, lng, rpt, held, lheld;
    } vec_t;

    vec_t tbl [12];
    int   n_long, n_rpt;

    initial begin
        // Short presses only: both instances must match these exact vectors.
        tbl[0]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        tbl[2]  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        tbl[3]  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        tbl[4]  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[5]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[6]  = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        tbl[7]  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[8]  = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        tbl[9]  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[10] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
        tbl[11] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};

        reset = 1'b0;
        sw_in = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state_rpt4", got_of(0), 12'h000);
        chk("reset_state_rpt0", got_of(1), 12'h000);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].sw);
            for (int d = 0; d < 2; d++)
                chk($sformatf("table_row%0d_dut%0d", i, d), got_of(d),
                    {tbl[i].press, tbl[i].rel, tbl[i].lng, tbl[i].rpt, tbl[i].held, tbl[i].lheld});
        end

        // Long press with repeat: ch0 high for 20 cycles, k = cycles after P.
        step(2'b01);
        for (int k = 1; k < 20; k++) begin
            step(2'b01);
            chk1($sformatf("long_k%0d", k), o_long[0][0], k == 8);
            chk1($sformatf("repeat_k%0d", k), o_rpt[0][0], k == 12 || k == 16);
            chk1($sformatf("long_held_k%0d", k), o_lheld[0][0], k >= 8);
        end
        step(2'b00);
        chk1("long_release_p20", o_rel[0][0], 1'b1);
        step(2'b00);

        // Release/long collision: high exactly 8 cycles.
        n_long = 0;
        for (int k = 0; k < 8; k++) begin
            step(2'b01);
            n_long += o_long[0][0];
        end
        step(2'b00);
        n_long += o_long[0][0];
        chk1("collision_release_p8", o_rel[0][0], 1'b1);
        chk1("collision_no_long", n_long == 0, 1'b1);
        step(2'b00);

        // Independence: ch1 pressed 3 cycles after ch0, each held 10 cycles.
        for (int t = 0; t < 15; t++) begin
            step({(t >= 3 && t < 13), (t < 10)});
            if (t == 8)  chk1("indep_ch0_long", o_long[0][0], 1'b1);
            if (t == 11) chk1("indep_ch1_long", o_long[0][1], 1'b1);
            if (t == 8)  chk1("indep_ch1_quiet", o_long[0][1], 1'b0);
        end

        // Reset while ch0 is in LONG, then release reset with ch0 still high.
        for (int k = 0; k < 12; k++) step(2'b01);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_rpt4", got_of(0), 12'h000);
        chk("async_reset_rpt0", got_of(1), 12'h000);
        model_reset();
        @(posedge clk);
        #1;
        chk("in_reset_no_release", got_of(0), 12'h000);
        reset = 1'b1;
        step(2'b01);
        chk1("press_after_reset", o_press[0][0], 1'b1);
        chk1("no_release_after_reset", o_rel[0][0], 1'b0);
        step(2'b00);
        step(2'b00);

        // Repeat disabled: hold ch0 for 30 cycles on both instances.
        n_long = 0;
        n_rpt  = 0;
        for (int k = 0; k < 30; k++) begin
            step(2'b01);
            if (k == 8) chk1("nr_long_p8", o_long[1][0], 1'b1);
            n_long += o_long[1][0];
            n_rpt  += o_rpt[1][0];
        end
        chk1("nr_one_long", n_long == 1, 1'b1);
        chk1("nr_zero_repeat", n_rpt == 0, 1'b1);
        step(2'b00);
        step(2'b00);

        // Randomised key activity, toggles sparse enough to reach LONG.
        for (int n = 0; n < 600; n++) begin
            logic [1:0] s;
            s = sw_in;
            for (int c = 0; c < 2; c++)
                if ($urandom_range(0, 9) == 0) s[c] = ~s[c];
            step(s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
